// File: rtl/bcd_display_sequencer.sv
// bcd_display_sequencer
//   Rotates one sequential double-dabble converter across four 12-bit sensor
//   channels and shows the result on a multiplexed 4-digit common-anode
//   7-segment display. Leading zeros are blanked. The decimal point of the
//   digit whose index matches the displayed channel is lit.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   ch_values  four 12-bit values, ch n = ch_values[12n+11:12n]
//   ch_enable  per-channel enable mask; disabled channels are skipped
//   hold       1 = keep re-converting the current channel every dwell
//   cur_ch     channel currently displayed
//   bcd_out    last conversion result, thousands digit in [15:12]
//   bcd_valid  one-cycle pulse when bcd_out updates
//   an         digit anodes, active-low one-hot, an[0] = units digit
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
module bcd_display_sequencer #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int SCAN_CYCLES  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] ch_values,
  input  logic [3:0]  ch_enable,
  input  logic        hold,
  output logic [1:0]  cur_ch,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam int SCAN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE, S_WAIT} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           cur_ch_reg, cur_ch_next;
  logic [11:0]          bin_reg, bin_next;
  logic [15:0]          acc_reg, acc_next;
  logic [3:0]           iter_reg, iter_next;
  logic [15:0]          bcd_out_reg, bcd_out_next;
  logic                 bcd_valid_reg, bcd_valid_next;
  logic                 disp_valid_reg, disp_valid_next;
  logic [DWELL_W-1:0]   dwell_reg, dwell_next;

  logic [SCAN_W-1:0]    scan_reg, scan_next;
  logic [1:0]           digit_reg, digit_next;
  logic [3:0]           an_reg, an_next;
  logic [6:0]           seg_reg, seg_next;
  logic                 dp_reg, dp_next;

  // ---------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------
  logic [1:0] rr_cand [4];
  logic [3:0] rr_hit;
  logic [1:0] lo_ch, rr_ch;
  logic       lo_found, rr_found;

  // Candidate order cur_ch+1, +2, +3, +4(=cur_ch) so the current channel is
  // considered last.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rr
      assign rr_cand[gi] = cur_ch_reg + 2'(gi + 1);
      assign rr_hit[gi]  = ch_enable[rr_cand[gi]];
    end
  endgenerate

  always_comb begin
    lo_found = 1'b0;
    lo_ch    = 2'd0;
    rr_found = 1'b0;
    rr_ch    = cur_ch_reg;
    // Scanning downward lets the lowest-priority index win last.
    for (int i = 3; i >= 0; i--) begin
      if (ch_enable[i]) begin
        lo_found = 1'b1;
        lo_ch    = 2'(i);
      end
      if (rr_hit[i]) begin
        rr_found = 1'b1;
        rr_ch    = rr_cand[i];
      end
    end
  end

  // ---------------------------------------------------------------
  // Double-dabble add-3 correction
  // ---------------------------------------------------------------
  // The top bit of the thousands nibble is shifted out on every step, so only
  // its low three bits after correction are kept.
  logic [14:0] acc_adj;
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] > 4'd4) ?
                                  acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
    end
  endgenerate
  assign acc_adj[14:12] = (acc_reg[15:12] > 4'd4) ? 3'(acc_reg[15:12] + 4'd3)
                                                  : acc_reg[14:12];

  // ---------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cur_ch_reg     <= 2'd0;
      bin_reg        <= 12'd0;
      acc_reg        <= 16'd0;
      iter_reg       <= 4'd0;
      bcd_out_reg    <= 16'd0;
      bcd_valid_reg  <= 1'b0;
      disp_valid_reg <= 1'b0;
      dwell_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cur_ch_reg     <= cur_ch_next;
      bin_reg        <= bin_next;
      acc_reg        <= acc_next;
      iter_reg       <= iter_next;
      bcd_out_reg    <= bcd_out_next;
      bcd_valid_reg  <= bcd_valid_next;
      disp_valid_reg <= disp_valid_next;
      dwell_reg      <= dwell_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_ch_next     = cur_ch_reg;
    bin_next        = bin_reg;
    acc_next        = acc_reg;
    iter_next       = iter_reg;
    bcd_out_next    = bcd_out_reg;
    bcd_valid_next  = 1'b0;
    disp_valid_next = disp_valid_reg;
    dwell_next      = dwell_reg;
    case (state_reg)
      S_IDLE: begin
        if (lo_found) begin
          cur_ch_next = lo_ch;
          state_next  = S_LOAD;
        end else begin
          state_next  = S_WAIT;
        end
      end
      S_LOAD: begin
        bin_next   = ch_values[12*cur_ch_reg +: 12];
        acc_next   = 16'd0;
        iter_next  = 4'd0;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        {acc_next, bin_next} = {acc_adj, bin_reg, 1'b0};
        iter_next = iter_reg + 4'd1;
        if (iter_reg == 4'd11) state_next = S_DONE;
      end
      S_DONE: begin
        bcd_out_next    = acc_reg;
        bcd_valid_next  = 1'b1;
        disp_valid_next = 1'b1;
        dwell_next      = '0;
        state_next      = S_WAIT;
      end
      S_WAIT: begin
        if (dwell_reg == DWELL_W'(DWELL_CYCLES - 1)) begin
          dwell_next = '0;
          if (hold) begin
            state_next = S_LOAD;
          end else if (rr_found) begin
            cur_ch_next = rr_ch;
            state_next  = S_LOAD;
          end else begin
            // Nothing to show: blank the display and try again next dwell.
            disp_valid_next = 1'b0;
          end
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  logic [3:0] nib_zero;
  logic [3:0] blank;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nz
      assign nib_zero[gi] = (bcd_out_reg[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // A digit is blank when it and every higher digit are zero; units never.
  always_comb begin
    blank[3] = ~disp_valid_reg | nib_zero[3];
    blank[2] = ~disp_valid_reg | (nib_zero[3] & nib_zero[2]);
    blank[1] = ~disp_valid_reg | (nib_zero[3] & nib_zero[2] & nib_zero[1]);
    blank[0] = ~disp_valid_reg;
  end

  // an/seg/dp are all registered from the same next digit index so they
  // switch together on one edge.
  always_comb begin
    if (scan_reg == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_next  = '0;
      digit_next = digit_reg + 2'd1;
    end else begin
      scan_next  = scan_reg + 1'b1;
      digit_next = digit_reg;
    end
    an_next  = ~(4'b0001 << digit_next);
    seg_next = blank[digit_next] ? 7'h7F : seg_code(bcd_out_reg[4*digit_next +: 4]);
    dp_next  = ~(disp_valid_reg & (digit_next == cur_ch_reg));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_reg  <= '0;
      digit_reg <= 2'd0;
      an_reg    <= 4'b1110;
      seg_reg   <= 7'h7F;
      dp_reg    <= 1'b1;
    end else begin
      scan_reg  <= scan_next;
      digit_reg <= digit_next;
      an_reg    <= an_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
    end
  end

  assign cur_ch    = cur_ch_reg;
  assign bcd_out   = bcd_out_reg;
  assign bcd_valid = bcd_valid_reg;
  assign an        = an_reg;
  assign seg       = seg_reg;
  assign dp        = dp_reg;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Directed testbench for bcd_display_sequencer (DWELL_CYCLES=32,
// SCAN_CYCLES=2). Inputs are driven and outputs sampled on the falling edge.
module tb_bcd_display_sequencer;

  localparam int DW = 32;
  localparam int SC = 2;
  localparam int PERIOD = DW + 14;  // bcd_valid spacing: dwell + load/shift/done

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] ch_values;
  logic [3:0]  ch_enable;
  logic        hold;
  logic [1:0]  cur_ch;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  bcd_display_sequencer #(.DWELL_CYCLES(DW), .SCAN_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .ch_values(ch_values), .ch_enable(ch_enable),
    .hold(hold), .cur_ch(cur_ch), .bcd_out(bcd_out), .bcd_valid(bcd_valid),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for the next bcd_valid pulse; cycles = negedges elapsed.
  task automatic wait_valid(input int bound, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (bcd_valid === 1'b1) seen = 1'b1;
    end
  endtask

  // Records seg/dp seen for each anode over one full scan rotation.
  task automatic capture_scan(output logic [27:0] segs, output logic [3:0] dps,
                              output bit bad);
    logic [3:0] seen_m;
    int k;
    seen_m = 4'h0;
    segs   = '1;
    dps    = '1;
    bad    = 1'b0;
    for (int c = 0; c < 4 * SC; c++) begin
      @(negedge clk);
      k = -1;
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: bad = 1'b1;
      endcase
      if (k >= 0) begin
        segs[7*k +: 7] = seg;
        dps[k]         = dp;
        seen_m[k]      = 1'b1;
      end
    end
    if (seen_m != 4'hF) bad = 1'b1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    hold      = 1'b0;
    ch_enable = 4'b1111;
    ch_values = {12'd1234, 12'd0, 12'd7, 12'd4095};
    tick(3);
    checks++; if (cur_ch !== 2'd0) begin failures++; $display("FAIL reset_cur_ch: got %0d expected 0", cur_ch); end
    checks++; if (bcd_out !== 16'h0000) begin failures++; $display("FAIL reset_bcd_out: got %h expected 0000", bcd_out); end
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL reset_bcd_valid: got %b expected 0", bcd_valid); end
    checks++; if (an !== 4'b1110) begin failures++; $display("FAIL reset_an: got %b expected 1110", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b expected 1", dp); end
    $display("reset: cur_ch=%0d bcd_out=%h an=%b seg=%h dp=%b", cur_ch, bcd_out, an, seg, dp);
  endtask

  task automatic test_full_scale;
    int n; bit seen; logic [27:0] segs; logic [3:0] dps; bit bad;
    rst = 1'b0;
    wait_valid(40, n, seen);
    checks++; if (!seen || n != 15) begin failures++; $display("FAIL fs_latency: got seen=%0d cycles=%0d expected cycles=15", seen, n); end
    checks++; if (bcd_out !== 16'h4095) begin failures++; $display("FAIL fs_bcd_out: got %h expected 4095", bcd_out); end
    checks++; if (cur_ch !== 2'd0) begin failures++; $display("FAIL fs_cur_ch: got %0d expected 0", cur_ch); end
    tick(1);
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL fs_pulse_width: got %b expected 0", bcd_valid); end
    capture_scan(segs, dps, bad);
    checks++; if (bad || segs !== {7'h19, 7'h40, 7'h10, 7'h12}) begin failures++; $display("FAIL fs_scan_seg: got %h bad=%0d expected %h", segs, bad, {7'h19, 7'h40, 7'h10, 7'h12}); end
    checks++; if (dps !== 4'b1110) begin failures++; $display("FAIL fs_scan_dp: got %b expected 1110", dps); end
    $display("full_scale: latency=%0d bcd_out=%h segs=%h dps=%b", n, bcd_out, segs, dps);
  endtask

  task automatic test_blanking;
    int n; bit seen; logic [27:0] segs; logic [3:0] dps; bit bad;
    wait_valid(60, n, seen);
    checks++; if (!seen || cur_ch !== 2'd1 || bcd_out !== 16'h0007) begin failures++; $display("FAIL blank_ch1: got seen=%0d ch=%0d bcd=%h expected ch=1 bcd=0007", seen, cur_ch, bcd_out); end
    capture_scan(segs, dps, bad);
    checks++; if (bad || segs !== {7'h7F, 7'h7F, 7'h7F, 7'h78}) begin failures++; $display("FAIL blank_ch1_seg: got %h bad=%0d expected %h", segs, bad, {7'h7F, 7'h7F, 7'h7F, 7'h78}); end
    checks++; if (dps !== 4'b1101) begin failures++; $display("FAIL blank_ch1_dp: got %b expected 1101", dps); end
    $display("blanking ch1: bcd_out=%h segs=%h dps=%b", bcd_out, segs, dps);
    wait_valid(60, n, seen);
    checks++; if (!seen || cur_ch !== 2'd2 || bcd_out !== 16'h0000) begin failures++; $display("FAIL blank_ch2: got seen=%0d ch=%0d bcd=%h expected ch=2 bcd=0000", seen, cur_ch, bcd_out); end
    capture_scan(segs, dps, bad);
    checks++; if (bad || segs !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL blank_ch2_seg: got %h bad=%0d expected %h", segs, bad, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    checks++; if (dps !== 4'b1011) begin failures++; $display("FAIL blank_ch2_dp: got %b expected 1011", dps); end
    $display("blanking ch2: bcd_out=%h segs=%h dps=%b", bcd_out, segs, dps);
  endtask

  task automatic test_round_robin;
    int n; bit seen;
    logic [1:0]  exp_ch  [3] = '{2'd3, 2'd0, 2'd3};
    logic [15:0] exp_bcd [3] = '{16'h0400, 16'h0100, 16'h0400};
    rst       = 1'b1;
    ch_values = {12'd400, 12'd300, 12'd200, 12'd100};
    ch_enable = 4'b1001;
    tick(2);
    rst = 1'b0;
    wait_valid(40, n, seen);
    checks++; if (!seen || n != 15 || cur_ch !== 2'd0 || bcd_out !== 16'h0100) begin failures++; $display("FAIL rr_first: got seen=%0d cycles=%0d ch=%0d bcd=%h expected cycles=15 ch=0 bcd=0100", seen, n, cur_ch, bcd_out); end
    $display("round_robin: ch=%0d bcd_out=%h", cur_ch, bcd_out);
    for (int i = 0; i < 3; i++) begin
      wait_valid(60, n, seen);
      checks++; if (!seen || n != PERIOD) begin failures++; $display("FAIL rr_period_%0d: got seen=%0d cycles=%0d expected %0d", i, seen, n, PERIOD); end
      checks++; if (cur_ch !== exp_ch[i] || bcd_out !== exp_bcd[i]) begin failures++; $display("FAIL rr_step_%0d: got ch=%0d bcd=%h expected ch=%0d bcd=%h", i, cur_ch, bcd_out, exp_ch[i], exp_bcd[i]); end
      $display("round_robin: ch=%0d bcd_out=%h period=%0d", cur_ch, bcd_out, n);
    end
  endtask

  task automatic test_hold;
    int n; bit seen;
    rst       = 1'b1;
    ch_values = {12'd789, 12'd123, 12'd22, 12'd11};
    ch_enable = 4'b1111;
    tick(2);
    rst = 1'b0;
    wait_valid(40, n, seen);
    wait_valid(60, n, seen);
    wait_valid(60, n, seen);
    checks++; if (!seen || cur_ch !== 2'd2 || bcd_out !== 16'h0123) begin failures++; $display("FAIL hold_reach_ch2: got seen=%0d ch=%0d bcd=%h expected ch=2 bcd=0123", seen, cur_ch, bcd_out); end
    hold = 1'b1;
    ch_values[35:24] = 12'd456;
    ch_enable = 4'b1011;  // current channel disabled; hold must still win
    wait_valid(60, n, seen);
    checks++; if (!seen || n != PERIOD || cur_ch !== 2'd2 || bcd_out !== 16'h0456) begin failures++; $display("FAIL hold_stay: got seen=%0d cycles=%0d ch=%0d bcd=%h expected ch=2 bcd=0456", seen, n, cur_ch, bcd_out); end
    $display("hold: ch=%0d bcd_out=%h", cur_ch, bcd_out);
    hold = 1'b0;
    wait_valid(60, n, seen);
    checks++; if (!seen || cur_ch !== 2'd3 || bcd_out !== 16'h0789) begin failures++; $display("FAIL hold_release: got seen=%0d ch=%0d bcd=%h expected ch=3 bcd=0789", seen, cur_ch, bcd_out); end
    $display("hold released: ch=%0d bcd_out=%h", cur_ch, bcd_out);
  endtask

  task automatic test_reset_mid_shift;
    int n; bit seen; bit pulsed;
    // Called on the pulse cycle of ch3; only ch1 enabled so the next pick is ch1.
    ch_enable = 4'b0010;
    ch_values[11:0] = 12'd4095;
    pulsed = 1'b0;
    // LOAD is entered 32 edges after the pulse; SHIFT iteration 6 is 7 later.
    repeat (39) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) pulsed = 1'b1;
    end
    checks++; if (pulsed) begin failures++; $display("FAIL mid_no_early_pulse: got pulse expected none"); end
    rst       = 1'b1;
    ch_enable = 4'b1111;
    tick(1);
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL mid_bcd_valid: got %b expected 0", bcd_valid); end
    checks++; if (cur_ch !== 2'd0 || bcd_out !== 16'h0000) begin failures++; $display("FAIL mid_state: got ch=%0d bcd=%h expected ch=0 bcd=0000", cur_ch, bcd_out); end
    checks++; if (an !== 4'b1110 || seg !== 7'h7F || dp !== 1'b1) begin failures++; $display("FAIL mid_display: got an=%b seg=%h dp=%b expected an=1110 seg=7f dp=1", an, seg, dp); end
    $display("reset mid shift: ch=%0d bcd_out=%h an=%b seg=%h dp=%b", cur_ch, bcd_out, an, seg, dp);
    rst = 1'b0;
    wait_valid(40, n, seen);
    checks++; if (!seen || n != 15 || cur_ch !== 2'd0 || bcd_out !== 16'h4095) begin failures++; $display("FAIL mid_restart: got seen=%0d cycles=%0d ch=%0d bcd=%h expected cycles=15 ch=0 bcd=4095", seen, n, cur_ch, bcd_out); end
    $display("restart after reset: ch=%0d bcd_out=%h latency=%0d", cur_ch, bcd_out, n);
  endtask

  task automatic test_all_disabled;
    int n; bit seen; bit pulsed; logic [27:0] segs; logic [3:0] dps; bit bad;
    ch_enable = 4'b0000;
    ch_values[23:12] = 12'd42;
    pulsed = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) pulsed = 1'b1;
    end
    checks++; if (pulsed) begin failures++; $display("FAIL off_no_pulse: got pulse expected none"); end
    checks++; if (cur_ch !== 2'd0) begin failures++; $display("FAIL off_cur_ch: got %0d expected 0", cur_ch); end
    capture_scan(segs, dps, bad);
    checks++; if (bad || segs !== 28'hFFFFFFF) begin failures++; $display("FAIL off_seg: got %h bad=%0d expected fffffff", segs, bad); end
    checks++; if (dps !== 4'b1111) begin failures++; $display("FAIL off_dp: got %b expected 1111", dps); end
    $display("all disabled: segs=%h dps=%b", segs, dps);
    ch_enable = 4'b0010;
    wait_valid(PERIOD + 4, n, seen);
    checks++; if (!seen || cur_ch !== 2'd1 || bcd_out !== 16'h0042) begin failures++; $display("FAIL off_resume: got seen=%0d ch=%0d bcd=%h expected ch=1 bcd=0042", seen, cur_ch, bcd_out); end
    capture_scan(segs, dps, bad);
    checks++; if (bad || segs !== {7'h7F, 7'h7F, 7'h19, 7'h24}) begin failures++; $display("FAIL off_resume_seg: got %h bad=%0d expected %h", segs, bad, {7'h7F, 7'h7F, 7'h19, 7'h24}); end
    checks++; if (dps !== 4'b1101) begin failures++; $display("FAIL off_resume_dp: got %b expected 1101", dps); end
    $display("re-enabled ch1: bcd_out=%h segs=%h dps=%b", bcd_out, segs, dps);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_blanking();
    test_round_robin();
    test_hold();
    test_reset_mid_shift();
    test_all_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_sequencer.md
Name: bcd_display_sequencer

Overview:
- Time-shares one sequential double-dabble binary-to-BCD converter between four 12-bit sensor channels (temperature, humidity, light, soil).
- Rotates through the enabled channels at a fixed dwell rate and converts the selected value.
- Drives a multiplexed 4-digit common-anode 7-segment display with leading-zero blanking and a channel-indicator decimal point.
- Sits between the sensor-value registers and the board display pins.

Parameters:
DWELL_CYCLES, 50000000, clock cycles each channel stays displayed (1 s at 50 MHz); minimum 16
SCAN_CYCLES, 50000, clock cycles each digit is driven during display scan; minimum 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ch_values  input  48  four 12-bit unsigned values; ch n = ch_values[12n+11:12n]
ch_enable  input  4  per-channel enable mask; disabled channels are skipped
hold  input  1  1 = stay on the current channel (value still refreshed every dwell)
cur_ch  output  2  channel currently displayed
bcd_out  output  16  last conversion result, 4 BCD digits, thousands in [15:12]
bcd_valid  output  1  one-cycle pulse when bcd_out updates
an  output  4  digit anodes, active-low one-hot, an[0] = units digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, cur_ch=0, bcd_out=0, bcd_valid=0, display-valid flag=0, dwell counter=0, scan counter=0, digit index=0, an=4'b1110, seg=7'h7F, dp=1.
- Reset mid-operation aborts any conversion; no bcd_valid pulse is issued.
- FSM states and transitions:
  - IDLE: select a channel, searching from ch0 upward. If one is found, go to LOAD; otherwise go to WAIT.
  - LOAD (1 cycle): snapshot the selected channel value into the shift register and clear the 16-bit BCD accumulator. Go to SHIFT.
  - SHIFT (12 cycles, iteration counter 0..11), each cycle:
    - Add 3 to every accumulator nibble whose value is >4.
    - Shift {acc, bin} left by 1, with the binary MSB entering acc[0].
    - After the 12th shift, go to DONE.
  - DONE (1 cycle): bcd_out <= acc, bcd_valid=1, display-valid flag=1. Clear the dwell counter and go to WAIT.
- Latency: bcd_out updates on the 14th clock edge after LOAD is entered. Later ch_values changes do not affect the conversion in progress.
- WAIT: count to DWELL_CYCLES-1, then select the next channel.
  - hold=1: reselect cur_ch even if it is now disabled.
  - hold=0: round-robin search starting at cur_ch+1 and wrapping; cur_ch itself is checked last.
  - Found: update cur_ch and go to LOAD.
  - None enabled: display-valid flag=0 (display blank), cur_ch unchanged, restart the dwell counter and remain in WAIT.
- ch_enable changes take effect only at the next selection point. An in-flight conversion always completes.
- Full range: 0..4095 maps to BCD 0x0000..0x4095. No saturation is needed.
- Display scan runs independently of the FSM:
  - The scan counter wraps at SCAN_CYCLES-1 and then advances the digit index 0→1→2→3→0.
  - an = ~(1<<index).
  - seg and dp are registered in the same cycle as an; there is no glitch between digits.
- Segment codes (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Leading-zero blanking:
  - Digit k (k=3..1) is blank if it and all higher digits are 0.
  - Digit 0 is always shown.
  - Everything is blank when the display-valid flag is 0.
- dp=0 only when digit index == cur_ch and the display-valid flag is 1; otherwise dp=1.

Test Plan:
- DWELL_CYCLES=32, SCAN_CYCLES=2, ch_enable=4'b1111, ch0=12'd4095, release rst → bcd_valid pulses exactly 14 cycles after LOAD; bcd_out=16'h4095; scan shows seg 19,40,10,12 on an[3..0].
- ch1=12'd7, ch2=12'd0 → ch1 shows digit0=78 with digits 3..1 blank (7F) and dp low on digit1; ch2 shows digit0=40 only.
- ch_enable=4'b1001, values 100/200/300/400 → cur_ch sequence 0,3,0,3 with one conversion per dwell; bcd_out 0x0100, 0x0400 alternating.
- hold=1 while on ch2, then change ch2 from 123 to 456 → cur_ch stays 2; next dwell gives bcd_out=0x0456; releasing hold advances to ch3.
- Assert rst during SHIFT iteration 6 → no bcd_valid pulse; all outputs return to reset values next cycle; after release, conversion restarts from ch0.
- ch_enable=0 after first display → at next dwell, seg=7F and dp=1 on all digits, no bcd_valid pulse; re-enabling ch1 resumes within one dwell with a correct value.
